mandelbrot_pixel_sink: RTL and testbench

//  Consumer end of the iteration-count stream: takes one 4-bit count per new_ctr pulse in raster order,

---
 rtl/mandelbrot_pkg.sv | 12 +
 rtl/mandelbrot_sync_fifo.sv | 42 ++++
 rtl/mandelbrot_pixel_sink.sv | 97 +++++++++
 tb/tb_mandelbrot_pixel_sink.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg: shared geometry defaults, FSM states and FIFO entry layout for the pixel sink
package mandelbrot_pkg;
  localparam int H_PIXELS_DEF = 640;
  localparam int V_PIXELS_DEF = 480;
  localparam int PIX_W = 4;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/mandelbrot_sync_fifo.sv
// mandelbrot_sync_fifo: first-word-fall-through FIFO over registered storage; full pushes are dropped
module mandelbrot_sync_fifo #(
  parameter int W = 10,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_wr, w_rd;
  assign full = r_count == CW'(DEPTH);
  assign empty = r_count == '0;
  assign count = r_count;
  assign dout = r_mem[r_rd];
  assign w_wr = push & ~full;
  assign w_rd = pop & ~empty;
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_rd) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= din;
endmodule

// File: rtl/mandelbrot_pixel_sink.sv
// mandelbrot_pixel_sink: packs the raster stream of 4-bit counts two per byte and serves them
// through a FIFO on a valid/ready port; the source is never stalled, overruns only set overflow.
module mandelbrot_pixel_sink
  import mandelbrot_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic             frame_done
);
  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_PIXELS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_PIXELS - 1);
  state_t r_state, w_next;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [PIX_W-1:0] r_held;
  logic r_overflow, r_frame_done;
  fifo_entry_t w_din, w_dout;
  logic [CW-1:0] w_count;
  logic w_full, w_empty, w_push, w_pop, w_clear, w_take, w_x_last, w_y_last, w_last_pop;
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE && start) ? ACTIVE :
             (w_take && w_x_last && w_y_last) ? DRAIN :
             (r_state == DRAIN && w_last_pop) ? IDLE : r_state;
  end
  always_comb begin
    w_clear = r_state == IDLE && start;
    w_take = r_state == ACTIVE && pix_valid;
    w_push = w_take && r_x[0];
    busy = r_state != IDLE;
  end
  assign w_x_last = r_x == X_LAST;
  assign w_y_last = r_y == Y_LAST;
  assign w_pop = out_valid & out_ready;
  assign w_last_pop = w_pop && w_count == CW'(1);
  assign w_din = '{sof: r_x == XW'(1) && r_y == '0, eol: w_x_last, data: {pix_data, r_held}};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
      r_held <= '0;
      r_overflow <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_state == DRAIN && w_last_pop;
      if (w_clear) begin
        r_x <= '0;
        r_y <= '0;
        r_held <= '0;
        r_overflow <= 1'b0;
      end else if (w_take) begin
        r_x <= w_x_last ? '0 : r_x + 1'b1;
        if (w_x_last) r_y <= w_y_last ? '0 : r_y + 1'b1;
        if (!r_x[0]) r_held <= pix_data;
        // geometry keeps advancing on a dropped byte so later bytes stay aligned
        if (w_push && w_full) r_overflow <= 1'b1;
      end
    end
  end
  mandelbrot_sync_fifo #(.W($bits(fifo_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .clear(w_clear),
    .push(w_push),
    .pop(w_pop),
    .din(w_din),
    .dout(w_dout),
    .full(w_full),
    .empty(w_empty),
    .count(w_count)
  );
  assign out_valid = ~w_empty;
  assign out_data = out_valid ? w_dout.data : '0;
  assign out_sof = out_valid ? w_dout.sof : 1'b0;
  assign out_eol = out_valid ? w_dout.eol : 1'b0;
  assign overflow = r_overflow;
  assign frame_done = r_frame_done;
endmodule

// File: tb/tb_mandelbrot_pixel_sink.sv
// tb_mandelbrot_pixel_sink: directed scenarios on a 4x2 frame with FIFO depths 4 (a) and 2 (b)
module tb_mandelbrot_pixel_sink;
  logic clk = 0, reset = 1;
  logic start = 0, pv = 0, rdy = 0;
  logic [3:0] pd = 0;
  logic [7:0] od;
  logic osof, oeol, ov, busy, ovf, fd;
  logic start2 = 0, pv2 = 0, rdy2 = 0;
  logic [3:0] pd2 = 0;
  logic [7:0] od2;
  logic osof2, oeol2, ov2, busy2, ovf2, fd2;
  int checks = 0, failures = 0;
  logic [9:0] cap[$], cap2[$];
  int fd_cnt = 0;

  always #5 clk = ~clk;

  mandelbrot_pixel_sink #(.H_PIXELS(4), .V_PIXELS(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pv), .pix_data(pd),
    .out_data(od), .out_sof(osof), .out_eol(oeol), .out_valid(ov), .out_ready(rdy),
    .busy(busy), .overflow(ovf), .frame_done(fd));
  mandelbrot_pixel_sink #(.H_PIXELS(4), .V_PIXELS(2), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .start(start2), .pix_valid(pv2), .pix_data(pd2),
    .out_data(od2), .out_sof(osof2), .out_eol(oeol2), .out_valid(ov2), .out_ready(rdy2),
    .busy(busy2), .overflow(ovf2), .frame_done(fd2));

  // inputs change 1 time unit after posedge, so the negedge view equals what the next posedge sees
  always @(negedge clk) begin
    if (ov && rdy) cap.push_back({osof, oeol, od});
    if (ov2 && rdy2) cap2.push_back({osof2, oeol2, od2});
    if (fd) fd_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_a(input logic [3:0] first);
    for (int i = 0; i < 8; i++) begin
      pv = 1; pd = first + 4'(i); tick();
    end
    pv = 0;
  endtask

  task automatic feed_b(input logic [3:0] first);
    for (int i = 0; i < 8; i++) begin
      pv2 = 1; pd2 = first + 4'(i); tick();
    end
    pv2 = 0;
  endtask

  task automatic test_reset();
    reset = 1; tick(); tick();
    checks++; if (ov !== 0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ov); end
    checks++; if (od !== 0) begin failures++; $display("FAIL reset_data got=%h exp=00", od); end
    checks++; if ({busy, ovf, fd} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, ovf, fd}); end
    checks++; if ({ov2, busy2, ovf2} !== 3'b000) begin failures++; $display("FAIL reset_b got=%b exp=000", {ov2, busy2, ovf2}); end
    reset = 0; tick();
  endtask

  task automatic test_basic_frame();
    logic [9:0] exp [4] = '{10'h221, 10'h143, 10'h065, 10'h187};
    bit seen = 0;
    cap.delete(); fd_cnt = 0; rdy = 1;
    start = 1; tick(); start = 0;
    checks++; if (busy !== 1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
    feed_a(4'h1);
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (fd) begin
        seen = 1;
        checks++; if (busy !== 0) begin failures++; $display("FAIL basic_busy_fall got=%b exp=0", busy); end
      end
    end
    checks++; if (!seen) begin failures++; $display("FAIL basic_frame_done got=0 exp=1"); end
    tick();
    checks++; if (fd !== 0 || fd_cnt != 1) begin failures++; $display("FAIL basic_fd_pulse got=%b/%0d exp=0/1", fd, fd_cnt); end
    checks++; if (cap.size() != 4) begin failures++; $display("FAIL basic_count got=%0d exp=4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap[i] !== exp[i]) begin failures++; $display("FAIL basic_byte%0d got=%h exp=%h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_back_pressure();
    logic [9:0] exp [4] = '{10'h221, 10'h143, 10'h065, 10'h187};
    bit seen = 0;
    cap.delete(); rdy = 0;
    start = 1; tick(); start = 0;
    feed_a(4'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({ov, osof, oeol, od} !== 11'h621) begin failures++; $display("FAIL bp_hold got=%h exp=621", {ov, osof, oeol, od}); end
    end
    checks++; if ({busy, ovf} !== 2'b10) begin failures++; $display("FAIL bp_flags got=%b exp=10", {busy, ovf}); end
    rdy = 1;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = fd; end
    checks++; if (!seen) begin failures++; $display("FAIL bp_frame_done got=0 exp=1"); end
    checks++; if (cap.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap[i] !== exp[i]) begin failures++; $display("FAIL bp_byte%0d got=%h exp=%h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_overrun();
    bit seen = 0;
    cap2.delete(); rdy2 = 0;
    start2 = 1; tick(); start2 = 0;
    feed_b(4'h1);
    checks++; if ({busy2, ovf2, od2} !== 10'h321) begin failures++; $display("FAIL ovr_state got=%h exp=321", {busy2, ovf2, od2}); end
    repeat (3) tick();
    checks++; if ({busy2, ovf2} !== 2'b11) begin failures++; $display("FAIL ovr_drain_hold got=%b exp=11", {busy2, ovf2}); end
    rdy2 = 1;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = fd2; end
    checks++; if (!seen) begin failures++; $display("FAIL ovr_frame_done got=0 exp=1"); end
    checks++; if (cap2.size() != 2 || cap2[0] !== 10'h221 || cap2[1] !== 10'h143) begin
      failures++; $display("FAIL ovr_bytes got=%0d:%h,%h exp=2:221,143", cap2.size(), cap2[0], cap2[1]);
    end
    checks++; if (ovf2 !== 1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", ovf2); end
    start2 = 1; tick(); start2 = 0;
    checks++; if (ovf2 !== 0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", ovf2); end
    rdy2 = 0;
    feed_b(4'h0);
    rdy2 = 1; repeat (4) tick(); rdy2 = 0;
  endtask

  task automatic test_full_pop();
    bit seen = 0;
    cap2.delete(); rdy2 = 0;
    start2 = 1; tick(); start2 = 0;
    for (int i = 1; i <= 8; i++) begin
      pv2 = 1; pd2 = 4'(i); rdy2 = i >= 6; tick();
    end
    pv2 = 0;
    checks++; if (ovf2 !== 1) begin failures++; $display("FAIL fp_overflow got=%b exp=1", ovf2); end
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = fd2; end
    checks++; if (!seen) begin failures++; $display("FAIL fp_frame_done got=0 exp=1"); end
    checks++; if (cap2.size() != 3 || cap2[0] !== 10'h221 || cap2[1] !== 10'h143 || cap2[2] !== 10'h187) begin
      failures++; $display("FAIL fp_bytes got=%0d:%h,%h,%h exp=3:221,143,187", cap2.size(), cap2[0], cap2[1], cap2[2]);
    end
  endtask

  task automatic test_gating();
    logic [9:0] exp [4] = '{10'h221, 10'h143, 10'h065, 10'h187};
    bit seen = 0;
    cap.delete(); rdy = 0;
    for (int i = 0; i < 3; i++) begin pv = 1; pd = 4'hF; tick(); end
    pv = 0; tick();
    checks++; if ({ov, busy} !== 2'b00) begin failures++; $display("FAIL gate_idle got=%b exp=00", {ov, busy}); end
    start = 1; tick(); start = 0;
    pv = 1; pd = 4'h1; tick(); pv = 0;
    start = 1; tick(); start = 0; tick();
    for (int i = 2; i <= 8; i++) begin pv = 1; pd = 4'(i); tick(); end
    for (int i = 0; i < 3; i++) begin pv = 1; pd = 4'hF; tick(); end
    pv = 0;
    checks++; if ({busy, ovf} !== 2'b10) begin failures++; $display("FAIL gate_drain got=%b exp=10", {busy, ovf}); end
    rdy = 1;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = fd; end
    checks++; if (!seen) begin failures++; $display("FAIL gate_frame_done got=0 exp=1"); end
    checks++; if (cap.size() != 4) begin failures++; $display("FAIL gate_count got=%0d exp=4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap[i] !== exp[i]) begin failures++; $display("FAIL gate_byte%0d got=%h exp=%h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] exp [4] = '{10'h2BA, 10'h1DC, 10'h0FE, 10'h110};
    bit seen = 0;
    rdy = 0;
    start = 1; tick(); start = 0;
    for (int i = 1; i <= 3; i++) begin pv = 1; pd = 4'(i); tick(); end
    pv = 0;
    checks++; if (ov !== 1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", ov); end
    reset = 1; tick(); reset = 0;
    checks++; if ({ov, busy, ovf, od} !== 11'h000) begin failures++; $display("FAIL mid_reset got=%h exp=000", {ov, busy, ovf, od}); end
    cap.delete(); rdy = 1;
    start = 1; tick(); start = 0;
    feed_a(4'hA);
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = fd; end
    checks++; if (!seen) begin failures++; $display("FAIL mid_frame_done got=0 exp=1"); end
    checks++; if (cap.size() != 4) begin failures++; $display("FAIL mid_count got=%0d exp=4", cap.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (cap[i] !== exp[i]) begin failures++; $display("FAIL mid_byte%0d got=%h exp=%h", i, cap[i], exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_pressure();
    test_overrun();
    test_full_pop();
    test_gating();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
